// File: rtl/bmp_pkg.sv
// Shared types, colour encodings and the default start-screen artwork
// for the monochrome bitmap drawers.
package bmp_pkg;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'h00;
    localparam logic [7:0] DEFAULT_ON_COLOR     = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        REVEAL,
        SHOW,
        BLINK_ON,
        BLINK_OFF
    } bmp_state_t;

    localparam int START_W = 55;
    localparam int START_H = 25;

    // Framed banner: one-pixel border plus a band of block "glyphs" across
    // the middle rows. Built procedurally so the artwork stays readable.
    function automatic logic [START_W*START_H-1:0] make_start_bmp();
        logic [START_W*START_H-1:0] b;
        b = '0;
        for (int r = 0; r < START_H; r++) begin
            for (int c = 0; c < START_W; c++) begin
                if (r == 0 || r == START_H-1 || c == 0 || c == START_W-1 ||
                    (r >= 8 && r <= 16 && c >= 3 && c <= START_W-4 &&
                     (c % 4) != 3 && (((c / 4) + r) % 2) == 0))
                    b[(START_H-1-r)*START_W + (START_W-1-c)] = 1'b1;
            end
        end
        return b;
    endfunction

    localparam logic [START_W*START_H-1:0] START_BMP = make_start_bmp();

endpackage

// File: rtl/mono_bitmap_rom.sv
// Combinational row/column lookup into a packed monochrome bitmap.
// Out-of-range coordinates report in_range=0 and never index the bitmap.
module mono_bitmap_rom #(
    parameter int                     OBJ_W  = 55,
    parameter int                     OBJ_H  = 25,
    parameter logic [OBJ_H*OBJ_W-1:0] BITMAP = '0
) (
    input  logic [10:0] row,
    input  logic [10:0] col,
    output logic        pixel,
    output logic        in_range
);

    localparam int          N     = OBJ_W * OBJ_H;
    localparam int          IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [10:0] H_LIM = 11'(OBJ_H);
    localparam logic [10:0] W_LIM = 11'(OBJ_W);

    logic [IDX_W-1:0] idx;

    // Row 0 sits in the MSB slice; column 0 is the MSB of its row.
    always_comb begin
        in_range = (row < H_LIM) && (col < W_LIM);
        idx      = '0;
        pixel    = 1'b0;
        if (in_range) begin
            idx   = IDX_W'((OBJ_H - 1 - int'(row)) * OBJ_W + (OBJ_W - 1 - int'(col)));
            pixel = BITMAP[idx];
        end
    end

endmodule

// File: rtl/blink_reveal_bitmap.sv
// Scaled monochrome bitmap drawer with a frame-synchronous top-down reveal
// wipe and optional blinking. All state changes happen on startOfFrame so
// a frame is never torn.
module blink_reveal_bitmap
    import bmp_pkg::*;
#(
    parameter int                     OBJ_W        = 55,
    parameter int                     OBJ_H        = 25,
    parameter int                     SCALE_SHIFT  = 1,
    parameter int                     REVEAL_STEP  = 1,
    parameter int                     BLINK_FRAMES = 30,
    parameter logic [OBJ_H*OBJ_W-1:0] BITMAP       = bmp_pkg::START_BMP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        InsideRectangle,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        blinkEn,
    input  logic [7:0]  colorIn,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic        visible
);

    localparam int RW = $clog2(OBJ_H + 1);
    localparam int RS = RW + 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [RS-1:0] STEP_SUM  = RS'(REVEAL_STEP);
    localparam logic [RS-1:0] H_SUM     = RS'(OBJ_H);
    localparam logic [BW-1:0] BLINK_END = BW'(BLINK_FRAMES - 1);

    bmp_state_t    state_q, state_d;
    logic [RW-1:0] reveal_row_q, reveal_row_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [7:0]    rgb_q, rgb_d;
    logic          draw_q, draw_d;
    logic          visible_q, visible_d;

    logic [RS-1:0] reveal_sum;
    logic [10:0]   row, col;
    logic          rom_pixel, rom_in_range;
    logic          shown, hit;

    assign row = offsetY >> SCALE_SHIFT;
    assign col = offsetX >> SCALE_SHIFT;

    mono_bitmap_rom #(
        .OBJ_W  (OBJ_W),
        .OBJ_H  (OBJ_H),
        .BITMAP (BITMAP)
    ) u_rom (
        .row      (row),
        .col      (col),
        .pixel    (rom_pixel),
        .in_range (rom_in_range)
    );

    // State, counters and registered pixel outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            reveal_row_q <= '0;
            blink_cnt_q  <= '0;
            rgb_q        <= TRANSPARENT_ENCODING;
            draw_q       <= 1'b0;
            visible_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            reveal_row_q <= reveal_row_d;
            blink_cnt_q  <= blink_cnt_d;
            rgb_q        <= rgb_d;
            draw_q       <= draw_d;
            visible_q    <= visible_d;
        end
    end

    // Next state: only evaluated on a frame tick; enable=0 beats blinkEn beats counter.
    always_comb begin
        state_d      = state_q;
        reveal_row_d = reveal_row_q;
        blink_cnt_d  = blink_cnt_q;
        reveal_sum   = {1'b0, reveal_row_q} + STEP_SUM;
        if (startOfFrame) begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d      = REVEAL;
                        reveal_row_d = '0;
                    end
                end
                REVEAL: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (reveal_sum >= H_SUM) begin
                        reveal_row_d = RW'(OBJ_H);
                        state_d      = SHOW;
                    end else begin
                        reveal_row_d = reveal_sum[RW-1:0];
                    end
                end
                SHOW: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (blinkEn) begin
                        state_d     = BLINK_ON;
                        blink_cnt_d = '0;
                    end
                end
                BLINK_ON, BLINK_OFF: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (!blinkEn) begin
                        state_d = SHOW;
                    end else if (blink_cnt_q == BLINK_END) begin
                        state_d     = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pixel hit, colour substitution and visibility flag.
    always_comb begin
        case (state_q)
            REVEAL:         shown = (row < 11'(reveal_row_q));
            SHOW, BLINK_ON: shown = 1'b1;
            default:        shown = 1'b0;
        endcase
        hit       = InsideRectangle && rom_in_range && rom_pixel && shown;
        rgb_d     = TRANSPARENT_ENCODING;
        if (hit)
            rgb_d = (colorIn == TRANSPARENT_ENCODING) ? DEFAULT_ON_COLOR : colorIn;
        draw_d    = hit;
        visible_d = (state_d == REVEAL) || (state_d == SHOW) || (state_d == BLINK_ON);
    end

    assign RGBout         = rgb_q;
    assign drawingRequest = draw_q;
    assign visible        = visible_q;

endmodule

// File: tb/tb_blink_reveal_bitmap.sv
// Directed bench for blink_reveal_bitmap: a 4x2 bitmap with only (0,0) and
// (3,1) set, drawn unscaled and at 2x scale from shared stimulus.
module tb_blink_reveal_bitmap;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] offsetX = '0;
    logic [10:0] offsetY = '0;
    logic        InsideRectangle = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        enable = 1'b0;
    logic        blinkEn = 1'b0;
    logic [7:0]  colorIn = 8'h1C;

    logic        dreq, vis, dreq_s, vis_s;
    logic [7:0]  rgb, rgb_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blink_reveal_bitmap #(
        .OBJ_W(4), .OBJ_H(2), .SCALE_SHIFT(0), .REVEAL_STEP(1),
        .BLINK_FRAMES(2), .BITMAP(8'b1000_0001)
    ) u_dut (
        .clk(clk), .reset(reset), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle), .startOfFrame(startOfFrame),
        .enable(enable), .blinkEn(blinkEn), .colorIn(colorIn),
        .drawingRequest(dreq), .RGBout(rgb), .visible(vis)
    );

    blink_reveal_bitmap #(
        .OBJ_W(4), .OBJ_H(2), .SCALE_SHIFT(1), .REVEAL_STEP(1),
        .BLINK_FRAMES(2), .BITMAP(8'b1000_0001)
    ) u_dut_s (
        .clk(clk), .reset(reset), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle), .startOfFrame(startOfFrame),
        .enable(enable), .blinkEn(blinkEn), .colorIn(colorIn),
        .drawingRequest(dreq_s), .RGBout(rgb_s), .visible(vis_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    // Present a pixel for one cycle and check the unscaled drawer's output.
    task automatic pix(input string tag, input int x, input int y, input logic [7:0] exp);
        offsetX = 11'(x);
        offsetY = 11'(y);
        step();
        chk({tag, ".rgb"}, 32'(rgb), 32'(exp));
        chk({tag, ".dreq"}, 32'(dreq), 32'(exp != 8'h00));
    endtask

    initial begin
        InsideRectangle = 1'b1;
        step();
        step();
        chk("rst.rgb", 32'(rgb), 32'h00);
        chk("rst.dreq", 32'(dreq), 32'h0);
        chk("rst.vis", 32'(vis), 32'h0);
        reset = 1'b0;
        pix("idle00", 0, 0, 8'h00);

        // Reveal wipe
        enable = 1'b1;
        tick();
        chk("rev0.vis", 32'(vis), 32'h1);
        pix("rev0_00", 0, 0, 8'h00);
        tick();
        pix("rev1_00", 0, 0, 8'h1C);
        pix("rev1_31", 3, 1, 8'h00);
        tick();
        pix("show_31", 3, 1, 8'h1C);
        pix("show_10", 1, 0, 8'h00);
        pix("show_40", 4, 0, 8'h00);
        pix("show_02", 0, 2, 8'h00);
        colorIn = 8'h00;
        pix("show_tcol", 0, 0, 8'hFF);
        colorIn = 8'h1C;

        // 2x scaled instance
        pix("sc_11", 1, 1, 8'h00);
        chk("sc_11.rgb_s", 32'(rgb_s), 32'h1C);
        chk("sc_11.dreq_s", 32'(dreq_s), 32'h1);
        pix("sc_20", 2, 0, 8'h00);
        chk("sc_20.rgb_s", 32'(rgb_s), 32'h00);
        InsideRectangle = 1'b0;
        pix("norect", 0, 0, 8'h00);
        chk("norect.rgb_s", 32'(rgb_s), 32'h00);
        InsideRectangle = 1'b1;

        // Blink
        blinkEn = 1'b1;
        tick();
        chk("bon.vis", 32'(vis), 32'h1);
        pix("bon_00", 0, 0, 8'h1C);
        tick();
        pix("bon2_00", 0, 0, 8'h1C);
        tick();
        chk("boff.vis", 32'(vis), 32'h0);
        pix("boff_00", 0, 0, 8'h00);
        tick();
        pix("boff2_00", 0, 0, 8'h00);
        tick();
        chk("bon3.vis", 32'(vis), 32'h1);
        pix("bon3_00", 0, 0, 8'h1C);
        blinkEn = 1'b0;
        tick();
        chk("show2.vis", 32'(vis), 32'h1);
        pix("show2_00", 0, 0, 8'h1C);
        tick();
        pix("show3_00", 0, 0, 8'h1C);

        // enable dropped mid-frame takes effect on next tick
        enable = 1'b0;
        pix("endrop_00", 0, 0, 8'h1C);
        chk("endrop.vis", 32'(vis), 32'h1);
        tick();
        chk("idle2.vis", 32'(vis), 32'h0);
        pix("idle2_00", 0, 0, 8'h00);

        // enable=0 beats blinkEn=1
        enable = 1'b1;
        tick();
        tick();
        tick();
        pix("show4_31", 3, 1, 8'h1C);
        enable  = 1'b0;
        blinkEn = 1'b1;
        tick();
        chk("prio.vis", 32'(vis), 32'h0);
        pix("prio_00", 0, 0, 8'h00);

        // Async reset in the middle of BLINK_ON
        enable  = 1'b1;
        blinkEn = 1'b0;
        tick();
        tick();
        tick();
        blinkEn = 1'b1;
        tick();
        pix("bon4_00", 0, 0, 8'h1C);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.rgb", 32'(rgb), 32'h00);
        chk("arst.dreq", 32'(dreq), 32'h0);
        chk("arst.vis", 32'(vis), 32'h0);
        step();
        chk("arst2.rgb", 32'(rgb), 32'h00);
        reset   = 1'b0;
        blinkEn = 1'b0;
        tick();
        chk("rerev.vis", 32'(vis), 32'h1);
        pix("rerev0_00", 0, 0, 8'h00);
        tick();
        pix("rerev1_00", 0, 0, 8'h1C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blink_reveal_bitmap.md
Name: blink_reveal_bitmap

Overview:
- Parametrised successor of the monochrome start-screen bitmap drawer.
- Adds generic bitmap size, power-of-two pixel scaling, and a programmable colour.
- Adds a frame-synchronous top-to-bottom reveal wipe and an optional blink animation.
- Sits between the screen-object rectangle logic and the drawing mux; used for title, "press start" and game-over banners.

Parameters:
- OBJ_W, 55, bitmap width in source pixels (1..64).
- OBJ_H, 25, bitmap height in source rows (1..64).
- SCALE_SHIFT, 1, each source pixel is drawn as a 2^SCALE_SHIFT square of screen pixels.
- REVEAL_STEP, 1, source rows revealed per frame during the wipe (>=1).
- BLINK_FRAMES, 30, frames per blink half-period (>=1).
- BITMAP, bmp_pkg::START_BMP, packed OBJ_H*OBJ_W bits.
  - Row r is BITMAP[(OBJ_H-r)*OBJ_W-1 -: OBJ_W].
  - Column c is bit OBJ_W-1-c of that row.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- offsetX  in  11  screen x offset from the object's top-left corner
- offsetY  in  11  screen y offset from the object's top-left corner
- InsideRectangle  in  1  pixel lies within the object bracket
- startOfFrame  in  1  one-cycle pulse per frame
- enable  in  1  request display; sampled only on startOfFrame
- blinkEn  in  1  request blinking; sampled only on startOfFrame
- colorIn  in  8  RGB332 colour for set bits
- drawingRequest  out  1  registered; pixel is to be displayed
- RGBout  out  8  registered pixel colour
- visible  out  1  state is REVEAL, SHOW or BLINK_ON

Behaviour:
- Reset: RGBout=8'h00, drawingRequest=0, visible=0, state=IDLE, revealRow=0, blinkCnt=0.
- Pixel path, one-cycle latency:
  - row = offsetY>>SCALE_SHIFT; col = offsetX>>SCALE_SHIFT, both unsigned 11-bit.
  - inRange = row<OBJ_H && col<OBJ_W.
  - Hit = InsideRectangle && inRange && bit(row,col) && shown(row).
  - shown(row): state REVEAL -> row<revealRow; SHOW or BLINK_ON -> 1; IDLE or BLINK_OFF -> 0.
  - On hit, RGBout <= colorIn, except colorIn==TRANSPARENT_ENCODING (8'h00) is replaced by 8'hFF.
  - On no hit, RGBout <= 8'h00.
  - drawingRequest <= hit, registered in the same cycle as RGBout, so drawingRequest==(RGBout!=0) always holds.
  - Out-of-range row/col never indexes the bitmap.
- FSM: every transition happens only on a cycle with startOfFrame=1, so no mid-frame tearing.
  - IDLE: enable=1 -> REVEAL, revealRow<=0.
  - REVEAL: enable=0 -> IDLE. Otherwise revealRow<=min(revealRow+REVEAL_STEP, OBJ_H). When the new value reaches OBJ_H -> SHOW.
  - SHOW: enable=0 -> IDLE. blinkEn=1 -> BLINK_ON, blinkCnt<=0.
  - BLINK_ON / BLINK_OFF:
    - enable=0 -> IDLE.
    - blinkEn=0 -> SHOW.
    - blinkCnt==BLINK_FRAMES-1 -> toggle ON<->OFF and blinkCnt<=0.
    - Otherwise blinkCnt++.
  - Priority when several conditions hold: enable=0 > blinkEn change > counter.
- Widths: revealRow is $clog2(OBJ_H+1) bits. The saturating add is computed one bit wider so it cannot wrap. blinkCnt is max(1,$clog2(BLINK_FRAMES)) bits.
- Reset mid-reveal or mid-blink: immediate return to IDLE with outputs cleared. A new reveal starts from row 0.
- visible is registered and updates with the state.
- startOfFrame while enable stays high in SHOW with blinkEn=0: no change.

Decomposition:
- bmp_pkg holds:
  - TRANSPARENT_ENCODING = 8'h00
  - DEFAULT_ON_COLOR = 8'hFF
  - typedef enum {IDLE, REVEAL, SHOW, BLINK_ON, BLINK_OFF} bmp_state_t
  - START_BMP constant
- One sub-module, mono_bitmap_rom (parameters OBJ_W, OBJ_H, BITMAP). It is a combinational lookup of row/col -> bit with an inRange output.
- FSM and output register live in the top module.

Test Plan (OBJ_W=4, OBJ_H=2, SCALE_SHIFT=0, REVEAL_STEP=1, BLINK_FRAMES=2, BITMAP=8'b1000_0001, colorIn=8'h1C):
- Reset asserted mid-BLINK_ON -> next edge RGBout=00, drawingRequest=0, visible=0. First frame after release with enable=1 enters REVEAL with revealRow=0.
- enable=1, one frame tick -> REVEAL, (0,0) transparent. Second tick: (0,0)=1C one cycle after presentation, (3,1) transparent. Third tick: SHOW, (3,1)=1C.
- In SHOW, (1,0), (4,0) and (0,2) presented -> RGBout=00 (clear bit / out of range). colorIn=00 at (0,0) -> RGBout=FF, drawingRequest=1.
- SHOW, blinkEn=1: tick -> BLINK_ON; 2 further ticks -> BLINK_OFF, (0,0) transparent, visible=0; 2 further ticks -> BLINK_ON. blinkEn=0 at a tick -> SHOW.
- enable dropped mid-frame -> drawing continues until the next startOfFrame, then IDLE. enable=0 together with blinkEn=1 on the same tick -> IDLE (enable wins).
- SCALE_SHIFT=1: offsets (1,1) -> source (0,0), drawn; (2,0) -> source (1,0), transparent. InsideRectangle=0 at (0,0) -> transparent.
